// File: rtl/board_io_pkg.sv
// Board-level I/O constants and types shared by the switch input path.
package board_io_pkg;

  localparam int SW_WIDTH    = 8;
  localparam int CLK_FREQ_HZ = 100000000;
  localparam int DEBOUNCE_MS = 10;

  localparam int DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  typedef logic [SW_WIDTH-1:0] sw_bus_t;

  // Counter width able to hold 0 .. cycles-1.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bus between the raw pins and the debounced consumer.
// Edge outputs exist only when SWITCH_DEBOUNCE_EDGE_EN is defined.
interface switch_debounce_if
  import board_io_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
) ();

  logic [WIDTH-1:0] switch_raw;
  logic [WIDTH-1:0] switch_clean;
  logic             switch_chg;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] switch_rise;
  logic [WIDTH-1:0] switch_fall;
`endif

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  modport master (
    output switch_raw,
    input  switch_clean,
    input  switch_chg,
    input  switch_rise,
    input  switch_fall
  );

  modport slave (
    input  switch_raw,
    output switch_clean,
    output switch_chg,
    output switch_rise,
    output switch_fall
  );
`else
  modport master (
    output switch_raw,
    input  switch_clean,
    input  switch_chg
  );

  modport slave (
    input  switch_raw,
    output switch_clean,
    output switch_chg
  );
`endif

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and clean flop.
// upd is high in the cycle whose edge will load the new clean value.
module debounce_bit
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic upd
);

  localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             differ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign differ = (sync2 != clean);
  assign upd    = differ && (cnt == CNT_MAX);

  // Any cycle that agrees with the accepted level restarts the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (upd) begin
      cnt   <= '0;
      clean <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounced slide-switch bus with a one-cycle change strobe.
// Define SWITCH_DEBOUNCE_EDGE_EN to add per-bit rise/fall strobes.
module switch_debounce
  import board_io_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_debounce_if.slave  sw
);

  localparam int CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] upd;
  logic             chg_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw.switch_raw[i]),
      .clean (clean[i]),
      .upd   (upd[i])
    );
  end

  // Strobes are loaded on the same edge as clean so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= |upd;
    end
  end

  assign sw.switch_clean = clean;
  assign sw.switch_chg   = chg_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & ~clean;
      fall_q <= upd & clean;
    end
  end

  assign sw.switch_rise = rise_q;
  assign sw.switch_fall = fall_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Randomised and directed bench for switch_debounce against a windowed reference model.
module tb_switch_debounce;
  import board_io_pkg::*;

  localparam int DC = 4;
  localparam int W  = SW_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_debounce_if #(.WIDTH(W)) sw ();

  switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw.slave)
  );

  int errors = 0;
  int checks = 0;
  int chg_seen = 0;

  // Reference: pins reach the debouncer two edges late; a bit flips once the
  // last DC delayed samples all disagree with the accepted level.
  logic [W-1:0] m_d1, m_d2, m_clean, m_rise, m_fall;
  logic         m_chg;
  logic [W-1:0] win[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_clean = '0;
    m_chg = 1'b0; m_rise = '0; m_fall = '0;
    win.delete();
  endtask

  task automatic check_outputs();
    chk("clean", 32'(sw.switch_clean), 32'(m_clean));
    chk("chg", 32'(sw.switch_chg), 32'(m_chg));
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    chk("rise", 32'(sw.switch_rise), 32'(m_rise));
    chk("fall", 32'(sw.switch_fall), 32'(m_fall));
`endif
  endtask

  task automatic tick();
    logic [W-1:0] nxt;
    bit all_diff;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      win.push_back(m_d2);
      if (win.size() > DC) void'(win.pop_front());
      nxt = m_clean;
      if (win.size() == DC) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (win[j]) if (win[j][b] == m_clean[b]) all_diff = 1'b0;
          if (all_diff) nxt[b] = ~m_clean[b];
        end
      end
      m_chg   = (nxt != m_clean);
      m_rise  = nxt & ~m_clean;
      m_fall  = ~nxt & m_clean;
      m_clean = nxt;
      m_d2    = m_d1;
      m_d1    = sw.switch_raw;
    end
    #1;
    check_outputs();
    if (sw.switch_chg) chg_seen++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Edges from now until switch_clean moves, bounded.
  task automatic measure(output int n);
    logic [W-1:0] prev;
    prev = sw.switch_clean;
    n = 0;
    while (sw.switch_clean == prev && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) chk("timeout", 32'(n), 32'(DC + 2));
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
  endtask

  int lat;
  logic [W-1:0] r;
  int bounce[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    sw.switch_raw = 8'hFF;
    assert_reset();
    ticks(5);
    chk("rst_hold_clean", 32'(sw.switch_clean), 32'h00);

    rst_n = 1'b1;
    chg_seen = 0;
    measure(lat);
    chk("rst_lat", 32'(lat), 32'(DC + 2));
    chk("rst_val", 32'(sw.switch_clean), 32'hFF);
    ticks(8);
    chk("rst_chg_cnt", 32'(chg_seen), 32'd1);

    sw.switch_raw = 8'h00;
    ticks(12);
    sw.switch_raw = 8'h01;
    chg_seen = 0;
    measure(lat);
    chk("step_lat", 32'(lat), 32'(DC + 2));
    chk("step_val", 32'(sw.switch_clean), 32'h01);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    chk("step_rise", 32'(sw.switch_rise), 32'h01);
`endif
    ticks(8);
    chk("step_chg_cnt", 32'(chg_seen), 32'd1);

    chg_seen = 0;
    foreach (bounce[k]) begin
      sw.switch_raw = 8'h01 | (W'(bounce[k]) << 3);
      tick();
    end
    ticks(10);
    chk("bounce_val", 32'(sw.switch_clean), 32'h09);
    chk("bounce_chg_cnt", 32'(chg_seen), 32'd1);

    sw.switch_raw = 8'h00;
    ticks(12);
    chg_seen = 0;
    sw.switch_raw = 8'h80;
    ticks(3);
    sw.switch_raw = 8'h00;
    ticks(10);
    chk("glitch_val", 32'(sw.switch_clean), 32'h00);
    chk("glitch_chg_cnt", 32'(chg_seen), 32'd0);

    sw.switch_raw = 8'hA5;
    chg_seen = 0;
    measure(lat);
    chk("simul_lat", 32'(lat), 32'(DC + 2));
    chk("simul_val", 32'(sw.switch_clean), 32'hA5);
    ticks(8);
    chk("simul_chg_cnt", 32'(chg_seen), 32'd1);

    sw.switch_raw = 8'h0F;
    ticks(2);
    assert_reset();
    ticks(3);
    chk("midrst_clean", 32'(sw.switch_clean), 32'h00);
    rst_n = 1'b1;
    measure(lat);
    chk("midrst_lat", 32'(lat), 32'(DC + 2));
    chk("midrst_val", 32'(sw.switch_clean), 32'h0F);

    r = 8'h0F;
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: r = r ^ W'($urandom);
        3, 4:    r = r ^ (W'(1) << $urandom_range(0, W - 1));
        5:       begin sw.switch_raw = r; ticks($urandom_range(DC, 3 * DC)); end
        default: ;
      endcase
      sw.switch_raw = r;
      tick();
    end

    sw.switch_raw = 8'h5A;
    ticks(12);
    chk("steady_val", 32'(sw.switch_clean), 32'h5A);
    chg_seen = 0;
    ticks(20);
    chk("steady_chg_cnt", 32'(chg_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream input-conditioning stage for the board's slide switches; output feeds the switch-to-LED register stage directly.
- Synchronises the raw 8-bit asynchronous switch bus into the clk domain.
- Debounces each bit independently; the value only changes after the input has held steady for a set number of cycles.
- Presents a clean, glitch-free 8-bit value plus a one-cycle change strobe.

Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a bit is accepted. Legal values are 2 or more. 1000000 gives 10 ms at 100 MHz.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the per-bit counter. Derived; do not override.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- switch_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- switch_clean  output  WIDTH  debounced switch value, registered.
- switch_chg  output  1  one-cycle pulse when any bit of switch_clean changes.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low (rst_n). The reset assertion edge is asynchronous; deassertion is assumed already synchronised externally.
  - While rst_n=0: both sync flops = 0, all counters = 0, switch_clean = 0, switch_chg = 0.
- Synchronizer:
  - Each bit passes through two flops: sync1 <= switch_raw, then sync2 <= sync1.
  - No logic is placed between the two flops.
- Per-bit debounce, evaluated on every rising clk edge:
  - If sync2[i] == switch_clean[i]: cnt[i] <= 0.
  - Else, if cnt[i] == DEBOUNCE_CYCLES-1: switch_clean[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Latency:
  - Take edge 0 as the edge on which sync1 first captures the new level.
  - switch_clean[i] updates on edge DEBOUNCE_CYCLES+1.
  - With DEBOUNCE_CYCLES=4, switch_clean changes at edge 5 and is visible in the cycle after it.
- Bounce rejection:
  - Any cycle with sync2[i] == switch_clean[i] clears cnt[i].
  - A pulse shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches switch_clean.
- Counter saturation:
  - cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Bit independence:
  - Bits are fully independent.
  - Several bits may update on the same edge; switch_chg is still a single pulse in that case.
- switch_chg:
  - Registered; equals 1 in exactly the cycles where switch_clean differs from its previous-cycle value.
  - Asserted in the same cycle the new switch_clean is first visible.
- Reset mid-count: any partial count is discarded; after rst_n rises, a full debounce interval is required again.
- Steady state: if switch_raw is held constant after reset, switch_clean converges to it and no further switch_chg pulses occur.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_EDGE_EN.
- Defined:
  - Adds outputs switch_rise[WIDTH-1:0] and switch_fall[WIDTH-1:0], both registered.
  - switch_rise[i] = 1 for exactly one cycle when switch_clean[i] goes 0->1; switch_fall[i] likewise for 1->0.
  - Both are aligned with switch_chg and reset to 0.
- Undefined: these ports and their flops do not exist; all other behaviour is identical.

Decomposition:
- Shared package (board_io_pkg):
  - SW_WIDTH = 8.
  - CLK_FREQ_HZ = 100000000.
  - DEBOUNCE_MS = 10.
  - Derived DEBOUNCE_CYCLES constant.
  - typedef sw_bus_t = logic [SW_WIDTH-1:0].
- One sub-module, debounce_bit:
  - Contains the synchronizer, counter and clean flop for one bit.
  - Instantiated WIDTH times with a generate loop.
  - The top level only adds switch_chg and the optional edge logic.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset: hold rst_n=0 with switch_raw=8'hFF -> switch_clean=8'h00 and switch_chg=0 throughout. Release rst_n -> switch_clean=8'hFF on edge 5 after release, with a single switch_chg pulse.
- Clean step: switch_raw 8'h00->8'h01, held -> switch_clean=8'h01 on edge 5; switch_chg high for exactly 1 cycle. With the macro defined, switch_rise=8'h01 in that same cycle.
- Bounce: bit 3 toggles with pattern 1,0,1,1,0,1,1,1,1,... -> switch_clean[3] changes only after 4 consecutive 1s at sync2, and exactly once.
- Glitch reject: 3-cycle pulse 8'h00->8'h80->8'h00 -> switch_clean stays 8'h00; no switch_chg.
- Simultaneous bits: switch_raw 8'h00->8'hA5 in one cycle -> switch_clean=8'hA5 on a single edge; exactly one switch_chg pulse.
- Reset mid-count: change switch_raw to 8'h0F, assert rst_n low after 2 edges, release -> switch_clean is 8'h00 during reset and reaches 8'h0F only 5 edges after release.
